// File: rtl/ibex_sram_port_arbiter.sv
// Shares one single-ported, 1-cycle-latency SRAM between the Ibex instruction and data
// request interfaces, with stall-stable locking and internally generated read valids.
module ibex_sram_port_arbiter #(
    parameter int AddrW      = 30,
    parameter int DataW      = 32,
    parameter bit RoundRobin = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             instr_req_i,
    output logic             instr_gnt_o,
    input  logic             instr_we_i,
    input  logic [AddrW-1:0] instr_addr_i,
    input  logic [DataW-1:0] instr_wdata_i,
    input  logic [DataW-1:0] instr_wmask_i,
    output logic [DataW-1:0] instr_rdata_o,
    output logic             instr_rvalid_o,

    input  logic             data_req_i,
    output logic             data_gnt_o,
    input  logic             data_we_i,
    input  logic [AddrW-1:0] data_addr_i,
    input  logic [DataW-1:0] data_wdata_i,
    input  logic [DataW-1:0] data_wmask_i,
    output logic [DataW-1:0] data_rdata_o,
    output logic             data_rvalid_o,

    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [DataW-1:0] mem_wdata_o,
    output logic [DataW-1:0] mem_wmask_o,
    input  logic [DataW-1:0] mem_rdata_i,

    output logic             arb_busy_o
);

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    owner_e r_lockOwner;
    owner_e r_lastGrant;
    owner_e w_winner;
    logic   r_lockValid;
    logic   r_instrRvalid;
    logic   r_dataRvalid;
    logic   w_req;

    // A stalled command keeps the port until it is granted, so the SRAM sees a stable request.
    always_comb begin
        w_winner = OWNER_INSTR;
        if (r_lockValid) begin
            w_winner = r_lockOwner;
        end else if (instr_req_i && !data_req_i) begin
            w_winner = OWNER_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            w_winner = OWNER_DATA;
        end else if (data_req_i && instr_req_i) begin
            if (RoundRobin) begin
                w_winner = (r_lastGrant == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
            end else begin
                w_winner = OWNER_DATA;
            end
        end
    end

    always_comb begin
        w_req       = rst_ni & ((w_winner == OWNER_DATA) ? data_req_i : instr_req_i);
        mem_req_o   = w_req;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (w_req) begin
            if (w_winner == OWNER_DATA) begin
                mem_we_o    = data_we_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
                mem_wmask_o = data_wmask_i;
            end else begin
                mem_we_o    = instr_we_i;
                mem_addr_o  = instr_addr_i;
                mem_wdata_o = instr_wdata_i;
                mem_wmask_o = instr_wmask_i;
            end
        end
    end

    assign instr_gnt_o    = mem_gnt_i & w_req & (w_winner == OWNER_INSTR);
    assign data_gnt_o     = mem_gnt_i & w_req & (w_winner == OWNER_DATA);
    assign arb_busy_o     = rst_ni & (instr_req_i | data_req_i) & ~(instr_gnt_o | data_gnt_o);

    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_rvalid_o = r_instrRvalid;
    assign data_rvalid_o  = r_dataRvalid;

    // A dropped request also clears the lock, since mem_req_o then falls to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lockValid   <= 1'b0;
            r_lockOwner   <= OWNER_INSTR;
            r_lastGrant   <= OWNER_INSTR;
            r_instrRvalid <= 1'b0;
            r_dataRvalid  <= 1'b0;
        end else begin
            r_lockValid   <= mem_req_o & ~mem_gnt_i;
            if (mem_req_o && !mem_gnt_i) begin
                r_lockOwner <= w_winner;
            end
            if (instr_gnt_o || data_gnt_o) begin
                r_lastGrant <= w_winner;
            end
            r_instrRvalid <= instr_gnt_o & ~instr_we_i;
            r_dataRvalid  <= data_gnt_o & ~data_we_i;
        end
    end

endmodule

// File: tb/tb_ibex_sram_port_arbiter.sv
// Self-checking bench for ibex_sram_port_arbiter: vector table plus scoreboard for read
// responses, and hand-written sequences for fixed priority and mid-flight reset.
module tb_ibex_sram_port_arbiter;

    localparam int AddrW = 30;
    localparam int DataW = 32;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam logic [AddrW-1:0] A0 = '0;
    localparam logic [DataW-1:0] Z  = '0;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             instr_req_i, instr_we_i, data_req_i, data_we_i, mem_gnt_i;
    logic [AddrW-1:0] instr_addr_i, data_addr_i;
    logic [DataW-1:0] instr_wdata_i, instr_wmask_i, data_wdata_i, data_wmask_i, mem_rdata_i;

    logic             instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic             mem_req_o, mem_we_o, arb_busy_o;
    logic [AddrW-1:0] mem_addr_o;
    logic [DataW-1:0] instr_rdata_o, data_rdata_o, mem_wdata_o, mem_wmask_o;

    logic             fpInstrGnt, fpInstrRvalid, fpDataGnt, fpDataRvalid;
    logic             fpMemReq, fpMemWe, fpBusy;
    logic [AddrW-1:0] fpMemAddr;
    logic [DataW-1:0] fpInstrRdata, fpDataRdata, fpMemWdata, fpMemWmask;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    always #5 clk_i = ~clk_i;

    ibex_sram_port_arbiter #(.AddrW(AddrW), .DataW(DataW), .RoundRobin(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_we_i(instr_we_i),
        .instr_addr_i(instr_addr_i), .instr_wdata_i(instr_wdata_i), .instr_wmask_i(instr_wmask_i),
        .instr_rdata_o(instr_rdata_o), .instr_rvalid_o(instr_rvalid_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_wmask_i(data_wmask_i),
        .data_rdata_o(data_rdata_o), .data_rvalid_o(data_rvalid_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
        .arb_busy_o(arb_busy_o)
    );

    ibex_sram_port_arbiter #(.AddrW(AddrW), .DataW(DataW), .RoundRobin(1'b0)) dutFp (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_gnt_o(fpInstrGnt), .instr_we_i(instr_we_i),
        .instr_addr_i(instr_addr_i), .instr_wdata_i(instr_wdata_i), .instr_wmask_i(instr_wmask_i),
        .instr_rdata_o(fpInstrRdata), .instr_rvalid_o(fpInstrRvalid),
        .data_req_i(data_req_i), .data_gnt_o(fpDataGnt), .data_we_i(data_we_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_wmask_i(data_wmask_i),
        .data_rdata_o(fpDataRdata), .data_rvalid_o(fpDataRvalid),
        .mem_req_o(fpMemReq), .mem_gnt_i(mem_gnt_i), .mem_we_o(fpMemWe), .mem_addr_o(fpMemAddr),
        .mem_wdata_o(fpMemWdata), .mem_wmask_o(fpMemWmask), .mem_rdata_i(mem_rdata_i),
        .arb_busy_o(fpBusy)
    );

    typedef struct {
        logic             iReq, iWe;
        logic [AddrW-1:0] iAddr;
        logic [DataW-1:0] iWdata, iWmask;
        logic             dReq, dWe;
        logic [AddrW-1:0] dAddr;
        logic [DataW-1:0] dWdata, dWmask;
        logic             memGnt;
        logic [DataW-1:0] memRdata;
        logic             eIGnt, eDGnt, eMemReq, eWe;
        logic [AddrW-1:0] eAddr;
        logic [DataW-1:0] eWdata, eWmask;
        logic             eBusy;
    } vec_t;

    typedef struct {
        logic owner;
        int   cycle;
    } resp_t;

    vec_t  vecs[$];
    resp_t sbQ[$];

    function automatic vec_t mkVec(
        input logic iReq, iWe, input logic [AddrW-1:0] iAddr, input logic [DataW-1:0] iWd, iWm,
        input logic dReq, dWe, input logic [AddrW-1:0] dAddr, input logic [DataW-1:0] dWd, dWm,
        input logic g, input logic [DataW-1:0] rd,
        input logic eI, eD, eR, eW, input logic [AddrW-1:0] eA, input logic [DataW-1:0] eWd, eWm,
        input logic eB);
        vec_t v;
        v = '{iReq:iReq, iWe:iWe, iAddr:iAddr, iWdata:iWd, iWmask:iWm,
              dReq:dReq, dWe:dWe, dAddr:dAddr, dWdata:dWd, dWmask:dWm,
              memGnt:g, memRdata:rd, eIGnt:eI, eDGnt:eD, eMemReq:eR, eWe:eW,
              eAddr:eA, eWdata:eWd, eWmask:eWm, eBusy:eB};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk_i);
        #1;
        cycle++;
        instr_req_i   = v.iReq;
        instr_we_i    = v.iWe;
        instr_addr_i  = v.iAddr;
        instr_wdata_i = v.iWdata;
        instr_wmask_i = v.iWmask;
        data_req_i    = v.dReq;
        data_we_i     = v.dWe;
        data_addr_i   = v.dAddr;
        data_wdata_i  = v.dWdata;
        data_wmask_i  = v.dWmask;
        mem_gnt_i     = v.memGnt;
        mem_rdata_i   = v.memRdata;
    endtask

    task automatic checkVector(input vec_t v);
        logic  expI, expD;
        resp_t r;
        @(negedge clk_i);
        checkOutput("instr_gnt", 32'(instr_gnt_o), 32'(v.eIGnt));
        checkOutput("data_gnt", 32'(data_gnt_o), 32'(v.eDGnt));
        checkOutput("mem_req", 32'(mem_req_o), 32'(v.eMemReq));
        checkOutput("mem_we", 32'(mem_we_o), 32'(v.eWe));
        checkOutput("mem_addr", 32'(mem_addr_o), 32'(v.eAddr));
        checkOutput("mem_wdata", mem_wdata_o, v.eWdata);
        checkOutput("mem_wmask", mem_wmask_o, v.eWmask);
        checkOutput("arb_busy", 32'(arb_busy_o), 32'(v.eBusy));
        expI = 1'b0;
        expD = 1'b0;
        if (sbQ.size() > 0 && sbQ[0].cycle == cycle) begin
            r = sbQ.pop_front();
            if (r.owner) expD = 1'b1;
            else         expI = 1'b1;
        end
        checkOutput("instr_rvalid", 32'(instr_rvalid_o), 32'(expI));
        checkOutput("data_rvalid", 32'(data_rvalid_o), 32'(expD));
        checkOutput("instr_rdata", instr_rdata_o, v.memRdata);
        checkOutput("data_rdata", data_rdata_o, v.memRdata);
        if (v.eIGnt && !v.iWe) sbQ.push_back('{owner: 1'b0, cycle: cycle + 1});
        if (v.eDGnt && !v.dWe) sbQ.push_back('{owner: 1'b1, cycle: cycle + 1});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t h;
        logic [DataW-1:0] iw, im, dw, dm;
        iw = 32'hAAAA0000; im = 32'hFFFF0000; dw = 32'h0000BBBB; dm = 32'h0000FFFF;

        // Single read, then round-robin contention with distinct write fields to prove the mux.
        vecs.push_back(mkVec(T,F,30'h100,Z,Z, F,F,A0,Z,Z, T,Z,            T,F,T,F,30'h100,Z,Z,F));
        vecs.push_back(mkVec(F,F,A0,Z,Z,      F,F,A0,Z,Z, T,32'hDEADBEEF, F,F,F,F,A0,Z,Z,F));
        vecs.push_back(mkVec(F,F,A0,Z,Z,      F,F,A0,Z,Z, F,32'h11111111, F,F,F,F,A0,Z,Z,F));
        vecs.push_back(mkVec(T,F,30'h200,iw,im, T,F,30'h300,dw,dm, T,Z,            F,T,T,F,30'h300,dw,dm,F));
        vecs.push_back(mkVec(T,F,30'h200,iw,im, T,F,30'h300,dw,dm, T,32'hA1A1A1A1, T,F,T,F,30'h200,iw,im,F));
        vecs.push_back(mkVec(T,F,30'h200,iw,im, T,F,30'h300,dw,dm, T,32'hA2A2A2A2, F,T,T,F,30'h300,dw,dm,F));
        vecs.push_back(mkVec(T,F,30'h200,iw,im, T,F,30'h300,dw,dm, T,32'hA3A3A3A3, T,F,T,F,30'h200,iw,im,F));
        vecs.push_back(mkVec(F,F,A0,Z,Z,      F,F,A0,Z,Z, F,32'hA4A4A4A4, F,F,F,F,A0,Z,Z,F));
        // Lock: instr stalls three cycles while data arrives and would otherwise win.
        vecs.push_back(mkVec(T,F,30'h400,Z,Z, F,F,A0,Z,Z,      F,Z,            F,F,T,F,30'h400,Z,Z,T));
        vecs.push_back(mkVec(T,F,30'h400,Z,Z, T,F,30'h500,Z,Z, F,Z,            F,F,T,F,30'h400,Z,Z,T));
        vecs.push_back(mkVec(T,F,30'h400,Z,Z, T,F,30'h500,Z,Z, F,Z,            F,F,T,F,30'h400,Z,Z,T));
        vecs.push_back(mkVec(T,F,30'h400,Z,Z, T,F,30'h500,Z,Z, T,Z,            T,F,T,F,30'h400,Z,Z,F));
        vecs.push_back(mkVec(F,F,A0,Z,Z,      T,F,30'h500,Z,Z, T,32'hCAFEF00D, F,T,T,F,30'h500,Z,Z,F));
        // Write passes through and produces no response.
        vecs.push_back(mkVec(F,F,A0,Z,Z, T,T,30'h600,32'h12345678,32'h0000FFFF, T,32'hB0B0B0B0,
                             F,T,T,T,30'h600,32'h12345678,32'h0000FFFF,F));
        vecs.push_back(mkVec(F,F,A0,Z,Z,      F,F,A0,Z,Z,      F,32'h22222222, F,F,F,F,A0,Z,Z,F));
        // Locked data owner drops its request: one dead cycle, then instr proceeds.
        vecs.push_back(mkVec(F,F,A0,Z,Z,      T,F,30'h700,Z,Z, F,Z,            F,F,T,F,30'h700,Z,Z,T));
        vecs.push_back(mkVec(T,F,30'h800,Z,Z, F,F,A0,Z,Z,      T,Z,            F,F,F,F,A0,Z,Z,T));
        vecs.push_back(mkVec(T,F,30'h800,Z,Z, F,F,A0,Z,Z,      T,Z,            T,F,T,F,30'h800,Z,Z,F));
        vecs.push_back(mkVec(F,F,A0,Z,Z,      F,F,A0,Z,Z,      F,32'h33333333, F,F,F,F,A0,Z,Z,F));
        // Instr write contending with a data read.
        vecs.push_back(mkVec(T,T,30'h900,32'h55,32'hFF, T,F,30'hA00,Z,Z, T,Z,
                             F,T,T,F,30'hA00,Z,Z,F));
        vecs.push_back(mkVec(T,T,30'h900,32'h55,32'hFF, T,F,30'hA00,Z,Z, T,32'h44444444,
                             T,F,T,T,30'h900,32'h55,32'hFF,F));
        vecs.push_back(mkVec(F,F,A0,Z,Z,      F,F,A0,Z,Z,      F,32'h66666666, F,F,F,F,A0,Z,Z,F));

        // Reset with both requesting and the SRAM granting: nothing may leak out.
        rst_ni = 1'b0;
        h = mkVec(T,F,30'h100,iw,im, T,F,30'h200,dw,dm, T,32'h77777777, F,F,F,F,A0,Z,Z,F);
        applyStimulus(h);
        @(negedge clk_i);
        checkOutput("reset mem_req", 32'(mem_req_o), 32'h0);
        checkOutput("reset instr_gnt", 32'(instr_gnt_o), 32'h0);
        checkOutput("reset data_gnt", 32'(data_gnt_o), 32'h0);
        checkOutput("reset busy", 32'(arb_busy_o), 32'h0);
        checkOutput("reset mem_addr", 32'(mem_addr_o), 32'h0);
        checkOutput("reset instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        checkOutput("reset data_rvalid", 32'(data_rvalid_o), 32'h0);
        h = '{default: '0};
        applyStimulus(h);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i]);
        end
        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);

        // Fixed priority: data wins every contended cycle.
        for (int k = 0; k < 4; k++) begin
            h = mkVec(T,F,30'hB00,Z,Z, T,F,30'hC00,dw,dm, T,32'h0F0F0000 + 32'(k), F,F,F,F,A0,Z,Z,F);
            applyStimulus(h);
            @(negedge clk_i);
            checkOutput("fp data_gnt", 32'(fpDataGnt), 32'h1);
            checkOutput("fp instr_gnt", 32'(fpInstrGnt), 32'h0);
            checkOutput("fp mem_req", 32'(fpMemReq), 32'h1);
            checkOutput("fp mem_addr", 32'(fpMemAddr), 32'h0C00);
            checkOutput("fp mem_wdata", fpMemWdata, dw);
            checkOutput("fp data_rvalid", 32'(fpDataRvalid), (k > 0) ? 32'h1 : 32'h0);
            checkOutput("fp instr_rvalid", 32'(fpInstrRvalid), 32'h0);
        end
        h = mkVec(T,F,30'hB00,iw,im, F,F,A0,Z,Z, T,32'h0F0F0004, F,F,F,F,A0,Z,Z,F);
        applyStimulus(h);
        @(negedge clk_i);
        checkOutput("fp lone instr_gnt", 32'(fpInstrGnt), 32'h1);
        checkOutput("fp lone mem_wmask", fpMemWmask, im);
        checkOutput("fp lone we", 32'(fpMemWe), 32'h0);
        checkOutput("fp lone busy", 32'(fpBusy), 32'h0);
        checkOutput("fp last data_rvalid", 32'(fpDataRvalid), 32'h1);
        checkOutput("fp data_rdata", fpDataRdata, 32'h0F0F0004);
        h = mkVec(F,F,A0,Z,Z, F,F,A0,Z,Z, F,32'h0F0F0005, F,F,F,F,A0,Z,Z,F);
        applyStimulus(h);
        @(negedge clk_i);
        checkOutput("fp instr_rvalid", 32'(fpInstrRvalid), 32'h1);
        checkOutput("fp instr_rdata", fpInstrRdata, 32'h0F0F0005);

        // Reset while a data read response is in flight; pointer must return to favour data.
        sbQ.delete();
        h = mkVec(F,F,A0,Z,Z, T,F,30'hD00,Z,Z, T,Z, F,F,F,F,A0,Z,Z,F);
        applyStimulus(h);
        @(negedge clk_i);
        checkOutput("pre-reset data_gnt", 32'(data_gnt_o), 32'h1);
        checkOutput("pre-reset mem_addr", 32'(mem_addr_o), 32'h0D00);
        h = mkVec(F,F,A0,Z,Z, F,F,A0,Z,Z, F,32'h88888888, F,F,F,F,A0,Z,Z,F);
        applyStimulus(h);
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("midreset data_rvalid", 32'(data_rvalid_o), 32'h0);
        checkOutput("midreset instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        h = mkVec(T,F,30'hE00,Z,Z, T,F,30'hF00,Z,Z, T,Z, F,F,F,F,A0,Z,Z,F);
        applyStimulus(h);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("post-reset data_gnt", 32'(data_gnt_o), 32'h1);
        checkOutput("post-reset instr_gnt", 32'(instr_gnt_o), 32'h0);
        checkOutput("post-reset mem_addr", 32'(mem_addr_o), 32'h0F00);
        h.memRdata = 32'h99999999;
        applyStimulus(h);
        @(negedge clk_i);
        checkOutput("post-reset 2nd instr_gnt", 32'(instr_gnt_o), 32'h1);
        checkOutput("post-reset data_rvalid", 32'(data_rvalid_o), 32'h1);
        checkOutput("post-reset instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        checkOutput("post-reset data_rdata", data_rdata_o, 32'h99999999);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
